store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Sits directly downstream of the store-formatting stage, which emits LSB-justified store data and a low-justified byte mask (0001/0011/1111).
- Aligns each store to its byte lanes using the address low bits and queues it in an in-order FIFO.
- Drains stores one per cycle to the data-memory write port with a valid/ready handshake.
- Decouples the pipeline from memory back-pressure and provides an empty flag for fence/sync.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, at least 2.
- AWIDTH, 32, byte address width.
- DWIDTH, 32, data width; fixed at 32 because the lane logic assumes 4 byte lanes.

Ports:
- sb_i_clk  in  1  clock, rising edge.
- sb_i_rst  in  1  reset, asynchronous, active-high.
- sb_i_valid  in  1  store request from upstream.
- sb_o_ready  out  1  buffer can accept; equals not full.
- sb_i_addr  in  AWIDTH  byte address of the store.
- sb_i_data  in  DWIDTH  LSB-justified store data.
- sb_i_mask  in  4  low-justified byte mask.
- sb_o_misalign  out  1  registered one-cycle pulse: store rejected as misaligned.
- sb_o_mem_valid  out  1  head entry is presented to memory.
- sb_i_mem_ready  in  1  memory accepts the head entry.
- sb_o_mem_addr  out  AWIDTH  word address; bits [1:0] are always 0.
- sb_o_mem_data  out  DWIDTH  lane-aligned data.
- sb_o_mem_mask  out  4  lane-aligned byte enables.
- sb_o_empty  out  1  no stores pending.
- sb_o_count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (asynchronous, active-high):
  - Clears wr_ptr, rd_ptr, count and misalign.
  - Outputs after reset: sb_o_ready=1, sb_o_mem_valid=0, sb_o_empty=1, sb_o_count=0, sb_o_misalign=0.
  - sb_o_mem_addr, sb_o_mem_data and sb_o_mem_mask are driven to 0 while empty.
  - Reset mid-drain discards all entries with no partial write; memory must ignore a valid that drops.
- Alignment (combinational, applied before the push):
  - lane = sb_i_addr[1:0].
  - aligned_mask = (sb_i_mask << lane), truncated to 4 bits.
  - aligned_data = sb_i_data << (8*lane).
  - Stored address = {sb_i_addr[AWIDTH-1:2], 2'b00}.
- Misalign: if any set bit of sb_i_mask shifts past bit 3 (for example half at lane 3, word at lane != 0):
  - The store is not pushed.
  - sb_o_misalign pulses high for exactly the cycle after the handshake.
  - The handshake still completes, so upstream is not stalled.
- Zero mask: valid with sb_i_mask=0 is consumed and not pushed, and is not flagged.
- Push occurs when sb_i_valid && sb_o_ready && mask legal and nonzero. The entry is written at wr_ptr, and wr_ptr wraps modulo DEPTH.
- Pop occurs when sb_o_mem_valid && sb_i_mem_ready. rd_ptr advances and wraps modulo DEPTH.
- sb_o_mem_valid = count != 0. Head fields are driven combinationally from the entry at rd_ptr.
- Latency: a push into an empty buffer is visible on sb_o_mem_valid the next cycle; there is no input-to-output bypass.
- Throughput: 1 push and 1 pop per cycle.
- Simultaneous push and pop: count is unchanged. This is legal at any non-full occupancy. At full, sb_o_ready=0, so only the pop happens.
- Full: count==DEPTH gives sb_o_ready=0. An upstream valid held at full is not consumed.
- Empty: a pop is impossible.
- Ordering: strictly FIFO. Memory sees stores in issue order.

Optional Feature:
- Macro: STORE_BUFFER_FWD_EN.
- When defined, the block adds a store-to-load check:
  - Inputs sb_i_ld_valid (1), sb_i_ld_addr (AWIDTH) and sb_i_ld_mask (4, already lane-aligned).
  - Outputs sb_o_fwd_hit, sb_o_fwd_data (DWIDTH) and sb_o_fwd_stall, all combinational.
- Selection: the youngest valid entry whose word address matches sb_i_ld_addr.
  - If that entry's mask covers sb_i_ld_mask: hit=1 and data=entry data; stall=0.
  - If the entry overlaps but does not fully cover: stall=1 and hit=0.
  - If there is no match, or sb_i_ld_valid=0: all outputs are 0.
- When the macro is not defined, these ports and the match logic do not exist.

Decomposition:
- Shared header: DWIDTH, AWIDTH defaults, the store-opcode constants and a BYTE_LANES=4 constant.
- One sub-module, store_lane_align (combinational): takes addr[1:0], data and mask; produces aligned data, aligned mask and the misalign flag.
- The FIFO pointers, count and the optional forwarding logic live in store_buffer.

Test Plan:
- Byte store, addr=0x1003, data=0x000000AB, mask=0001 -> after 1 cycle: mem_addr=0x1000, mem_data=0xAB000000, mem_mask=1000.
- Half store at addr=0x2003, mask=0011 -> no push, misalign pulses 1 cycle, count stays 0. A word store at 0x2002 behaves the same way.
- mem_ready=0, push 5 word stores with DEPTH=4 -> ready drops after the 4th, count=4, 5th held. Then mem_ready=1 -> drains in order, and the 5th is accepted on the first free cycle.
- Full buffer with push and pop in the same cycle -> ready=0, so pop only, count 4->3. At count=2, push and pop together -> count stays 2 and pointers wrap correctly over 10 iterations.
- Reset asserted with 3 entries pending while mem_valid=1 -> immediately empty=1, mem_valid=0, count=0.
- With STORE_BUFFER_FWD_EN: store word 0x11223344 at 0x40, then byte 0xFF at 0x41.
  - Load addr=0x40, mask=0010 -> hit=1, data has 0xFF in byte 1.
  - Load mask=1111 -> stall=1.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared constants for the store buffer: default widths, byte-lane count and store opcodes.
package store_buffer_pkg;

   localparam int AWIDTH_DEF = 32;
   localparam int DWIDTH_DEF = 32;
   localparam int BYTE_LANES = 4;

   typedef enum logic [1:0] {
      ST_BYTE = 2'b00,
      ST_HALF = 2'b01,
      ST_WORD = 2'b10
   } store_op_e;

   // Low-justified byte mask that the store-formatting stage emits for each opcode.
   function automatic logic [BYTE_LANES-1:0] op_mask(store_op_e op);
      case (op)
         ST_BYTE: op_mask = 4'b0001;
         ST_HALF: op_mask = 4'b0011;
         ST_WORD: op_mask = 4'b1111;
         default: op_mask = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Store buffer bus bundle: upstream store request, memory write port and status.
// Forwarding signals exist only when STORE_BUFFER_FWD_EN is defined.
interface store_buffer_if
   import store_buffer_pkg::*;
#(
   parameter int AWIDTH = AWIDTH_DEF,
   parameter int DWIDTH = DWIDTH_DEF,
   parameter int DEPTH  = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic                  sb_i_valid;
   logic                  sb_o_ready;
   logic [AWIDTH-1:0]     sb_i_addr;
   logic [DWIDTH-1:0]     sb_i_data;
   logic [BYTE_LANES-1:0] sb_i_mask;
   logic                  sb_o_misalign;
   logic                  sb_o_mem_valid;
   logic                  sb_i_mem_ready;
   logic [AWIDTH-1:0]     sb_o_mem_addr;
   logic [DWIDTH-1:0]     sb_o_mem_data;
   logic [BYTE_LANES-1:0] sb_o_mem_mask;
   logic                  sb_o_empty;
   logic [CW-1:0]         sb_o_count;
`ifdef STORE_BUFFER_FWD_EN
   logic                  sb_i_ld_valid;
   logic [AWIDTH-1:0]     sb_i_ld_addr;
   logic [BYTE_LANES-1:0] sb_i_ld_mask;
   logic                  sb_o_fwd_hit;
   logic [DWIDTH-1:0]     sb_o_fwd_data;
   logic                  sb_o_fwd_stall;
`endif

   modport slave (
`ifdef STORE_BUFFER_FWD_EN
      input  sb_i_ld_valid, sb_i_ld_addr, sb_i_ld_mask,
      output sb_o_fwd_hit, sb_o_fwd_data, sb_o_fwd_stall,
`endif
      input  sb_i_valid, sb_i_addr, sb_i_data, sb_i_mask, sb_i_mem_ready,
      output sb_o_ready, sb_o_misalign, sb_o_mem_valid, sb_o_mem_addr,
      output sb_o_mem_data, sb_o_mem_mask, sb_o_empty, sb_o_count
   );

   modport master (
`ifdef STORE_BUFFER_FWD_EN
      output sb_i_ld_valid, sb_i_ld_addr, sb_i_ld_mask,
      input  sb_o_fwd_hit, sb_o_fwd_data, sb_o_fwd_stall,
`endif
      output sb_i_valid, sb_i_addr, sb_i_data, sb_i_mask, sb_i_mem_ready,
      input  sb_o_ready, sb_o_misalign, sb_o_mem_valid, sb_o_mem_addr,
      input  sb_o_mem_data, sb_o_mem_mask, sb_o_empty, sb_o_count
   );

endinterface

// File: rtl/store_lane_align.sv
// Moves LSB-justified store data and mask onto their byte lanes; flags masks that
// would spill past the top lane.
module store_lane_align
   import store_buffer_pkg::*;
(
   input  logic [1:0]              lane,
   input  logic [BYTE_LANES*8-1:0] data,
   input  logic [BYTE_LANES-1:0]   mask,
   output logic [BYTE_LANES*8-1:0] aligned_data,
   output logic [BYTE_LANES-1:0]   aligned_mask,
   output logic                    misalign
);
   // Double-width mask so any bit pushed past lane 3 stays visible in the upper half.
   logic [2*BYTE_LANES-1:0] wide_mask;

   assign wide_mask    = {{BYTE_LANES{1'b0}}, mask} << lane;
   assign aligned_mask = wide_mask[BYTE_LANES-1:0];
   assign misalign     = |wide_mask[2*BYTE_LANES-1:BYTE_LANES];
   assign aligned_data = data << {lane, 3'b000};

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer: lane-aligns stores, queues DEPTH entries and drains one per
// cycle to the memory write port. Define STORE_BUFFER_FWD_EN for the store-to-load check.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int AWIDTH = AWIDTH_DEF,
   parameter int DWIDTH = DWIDTH_DEF
) (
   input logic           sb_i_clk,
   input logic           sb_i_rst,
   store_buffer_if.slave sb
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [CW-1:0]         count;
   logic                  misalign_q;
   logic [AWIDTH-1:0]     addr_mem [DEPTH];
   logic [DWIDTH-1:0]     data_mem [DEPTH];
   logic [BYTE_LANES-1:0] mask_mem [DEPTH];

   logic [DWIDTH-1:0]     al_data;
   logic [BYTE_LANES-1:0] al_mask;
   logic                  al_misalign;
   logic                  full, accept, push, pop, head_valid;

   store_lane_align u_align (
      .lane         (sb.sb_i_addr[1:0]),
      .data         (sb.sb_i_data),
      .mask         (sb.sb_i_mask),
      .aligned_data (al_data),
      .aligned_mask (al_mask),
      .misalign     (al_misalign)
   );

   // Misaligned and zero-mask requests still complete the handshake but never enter the queue.
   assign full       = (count == CW'(DEPTH));
   assign accept     = sb.sb_i_valid && !full;
   assign push       = accept && !al_misalign && (sb.sb_i_mask != '0);
   assign head_valid = (count != '0);
   assign pop        = head_valid && sb.sb_i_mem_ready;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge sb_i_clk or posedge sb_i_rst) begin
      if (sb_i_rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         misalign_q <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         misalign_q <= accept && al_misalign;
      end
   end

   // NOTE: entry storage has no reset; count gates every read, so stale contents are never observed.
   always_ff @(posedge sb_i_clk) begin
      if (push) begin
         addr_mem[wr_ptr] <= {sb.sb_i_addr[AWIDTH-1:2], 2'b00};
         data_mem[wr_ptr] <= al_data;
         mask_mem[wr_ptr] <= al_mask;
      end
   end

   assign sb.sb_o_ready     = !full;
   assign sb.sb_o_misalign  = misalign_q;
   assign sb.sb_o_mem_valid = head_valid;
   assign sb.sb_o_empty     = !head_valid;
   assign sb.sb_o_count     = count;
   assign sb.sb_o_mem_addr  = head_valid ? addr_mem[rd_ptr] : '0;
   assign sb.sb_o_mem_data  = head_valid ? data_mem[rd_ptr] : '0;
   assign sb.sb_o_mem_mask  = head_valid ? mask_mem[rd_ptr] : '0;

`ifdef STORE_BUFFER_FWD_EN
   logic          fwd_found, fwd_cover, fwd_overlap;
   logic [PW-1:0] fwd_sel, fwd_idx;

   // Walk oldest to youngest so the last match wins.
   // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
   always_comb begin
      fwd_found = 1'b0;
      fwd_sel   = '0;
      fwd_idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_idx = rd_ptr + PW'(i);
         if (CW'(i) < count &&
             addr_mem[fwd_idx][AWIDTH-1:2] == sb.sb_i_ld_addr[AWIDTH-1:2]) begin
            fwd_found = 1'b1;
            fwd_sel   = fwd_idx;
         end
      end
   end

   assign fwd_overlap       = |(mask_mem[fwd_sel] & sb.sb_i_ld_mask);
   assign fwd_cover         = (sb.sb_i_ld_mask != '0) &&
                              ((sb.sb_i_ld_mask & ~mask_mem[fwd_sel]) == '0);
   assign sb.sb_o_fwd_hit   = sb.sb_i_ld_valid && fwd_found && fwd_cover;
   assign sb.sb_o_fwd_stall = sb.sb_i_ld_valid && fwd_found && fwd_overlap && !fwd_cover;
   assign sb.sb_o_fwd_data  = sb.sb_o_fwd_hit ? data_mem[fwd_sel] : '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_store_buffer;
   import store_buffer_pkg::*;

   localparam int DEPTH = 4;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   ent_t model_q[$];
   int   total  = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   store_buffer_if #(.AWIDTH(32), .DWIDTH(32), .DEPTH(DEPTH)) sbif ();

   store_buffer #(.DEPTH(DEPTH), .AWIDTH(32), .DWIDTH(32)) dut (
      .sb_i_clk (clk),
      .sb_i_rst (rst),
      .sb       (sbif.slave)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Reference alignment from arithmetic on the lane number.
   task automatic model_align(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] mask, output ent_t e, output bit mis);
      int lane, wide;
      longint unsigned d;
      lane   = int'(addr % 4);
      wide   = int'(mask) * (1 << lane);
      mis    = (wide > 15);
      d      = longint'(data) * (64'd1 << (8 * lane));
      e.addr = addr - (addr % 4);
      e.data = d[31:0];
      e.mask = 4'(wide % 16);
   endtask

   // One clock: check state-derived outputs, advance, update model, check misalign.
   task automatic cycle();
      bit   acc, do_pop, mis;
      ent_t e;
      check("ready",  sbif.sb_o_ready,     model_q.size() < DEPTH);
      check("count",  sbif.sb_o_count,     model_q.size());
      check("empty",  sbif.sb_o_empty,     model_q.size() == 0);
      check("mvalid", sbif.sb_o_mem_valid, model_q.size() != 0);
      if (model_q.size() != 0) begin
         check("maddr", sbif.sb_o_mem_addr, model_q[0].addr);
         check("mdata", sbif.sb_o_mem_data, model_q[0].data);
         check("mmask", sbif.sb_o_mem_mask, model_q[0].mask);
      end else begin
         check("maddr0", sbif.sb_o_mem_addr, 0);
         check("mdata0", sbif.sb_o_mem_data, 0);
         check("mmask0", sbif.sb_o_mem_mask, 0);
      end
      acc    = sbif.sb_i_valid && (model_q.size() < DEPTH);
      do_pop = (model_q.size() != 0) && sbif.sb_i_mem_ready;
      model_align(sbif.sb_i_addr, sbif.sb_i_data, sbif.sb_i_mask, e, mis);
      @(posedge clk);
      #1;
      if (do_pop) void'(model_q.pop_front());
      if (acc && !mis && sbif.sb_i_mask != 0) model_q.push_back(e);
      check("misalign", sbif.sb_o_misalign, acc && mis);
   endtask

   task automatic drive(input logic valid, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] mask);
      sbif.sb_i_valid = valid;
      sbif.sb_i_addr  = addr;
      sbif.sb_i_data  = data;
      sbif.sb_i_mask  = mask;
   endtask

   // Holds a request until the model says it is taken; bounded wait.
   task automatic push_store(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] mask);
      int n = 0;
      drive(1'b1, addr, data, mask);
      while (model_q.size() >= DEPTH && n < 50) begin
         cycle();
         n++;
      end
      if (n == 50) begin
         total++;
         $error("FAIL push_timeout: observed busy expected accept");
      end
      cycle();
      sbif.sb_i_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1);
   end

   initial begin
      drive(1'b0, '0, '0, '0);
      sbif.sb_i_mem_ready = 1'b0;
`ifdef STORE_BUFFER_FWD_EN
      sbif.sb_i_ld_valid = 1'b0;
      sbif.sb_i_ld_addr  = '0;
      sbif.sb_i_ld_mask  = '0;
`endif
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_ready",    sbif.sb_o_ready,     1);
      check("rst_mvalid",   sbif.sb_o_mem_valid, 0);
      check("rst_empty",    sbif.sb_o_empty,     1);
      check("rst_count",    sbif.sb_o_count,     0);
      check("rst_misalign", sbif.sb_o_misalign,  0);

      // Byte store at lane 3
      push_store(32'h1003, 32'h0000_00AB, op_mask(ST_BYTE));
      check("byte_addr", sbif.sb_o_mem_addr, 32'h1000);
      check("byte_data", sbif.sb_o_mem_data, 32'hAB00_0000);
      check("byte_mask", sbif.sb_o_mem_mask, 4'b1000);
      sbif.sb_i_mem_ready = 1'b1;
      cycle();
      sbif.sb_i_mem_ready = 1'b0;

      // Misaligned half and word: consumed, flagged for one cycle, not queued
      push_store(32'h2003, 32'h0000_1234, op_mask(ST_HALF));
      check("half_mis",   sbif.sb_o_misalign, 1);
      check("half_count", sbif.sb_o_count,    0);
      cycle();
      check("half_pulse", sbif.sb_o_misalign, 0);
      push_store(32'h2002, 32'h1234_5678, op_mask(ST_WORD));
      check("word_mis",   sbif.sb_o_misalign, 1);
      check("word_count", sbif.sb_o_count,    0);
      cycle();
      check("word_pulse", sbif.sb_o_misalign, 0);

      // Zero mask: consumed silently
      push_store(32'h3000, 32'hDEAD_BEEF, 4'b0000);
      check("zero_count", sbif.sb_o_count,    0);
      check("zero_mis",   sbif.sb_o_misalign, 0);

      // Fill to full with memory stalled, fifth request held
      for (int i = 0; i < DEPTH; i++) push_store(32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF);
      check("full_ready", sbif.sb_o_ready, 0);
      check("full_count", sbif.sb_o_count, 4);
      drive(1'b1, 32'h200, 32'hCAFE_F00D, 4'hF);
      repeat (2) cycle();
      check("held_count", sbif.sb_o_count, 4);
      sbif.sb_i_mem_ready = 1'b1;
      cycle();
      check("full_pop_only", sbif.sb_o_count, 3);
      cycle();
      check("fifth_in", sbif.sb_o_count, 3);
      sbif.sb_i_valid = 1'b0;
      while (model_q.size() > 2) cycle();

      // Concurrent push and pop at count 2 across pointer wrap
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 32'h400 + 32'(4 * i), $urandom, 4'hF);
         cycle();
         check("steady_count", sbif.sb_o_count, 2);
      end
      sbif.sb_i_valid = 1'b0;
      repeat (3) cycle();

      // Reset mid-drain
      sbif.sb_i_mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) push_store(32'h500 + 32'(4 * i), 32'(i), 4'hF);
      sbif.sb_i_mem_ready = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      check("mrst_empty",  sbif.sb_o_empty,     1);
      check("mrst_mvalid", sbif.sb_o_mem_valid, 0);
      check("mrst_count",  sbif.sb_o_count,     0);
      check("mrst_addr",   sbif.sb_o_mem_addr,  0);
      model_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;

`ifdef STORE_BUFFER_FWD_EN
      sbif.sb_i_mem_ready = 1'b0;
      push_store(32'h40, 32'h1122_3344, 4'hF);
      push_store(32'h41, 32'h0000_00FF, 4'h1);
      sbif.sb_i_ld_valid = 1'b1;
      sbif.sb_i_ld_addr  = 32'h40;
      sbif.sb_i_ld_mask  = 4'b0010;
      #1;
      check("fwd_hit",   sbif.sb_o_fwd_hit,   1);
      check("fwd_byte1", sbif.sb_o_fwd_data[15:8], 8'hFF);
      check("fwd_nost",  sbif.sb_o_fwd_stall, 0);
      sbif.sb_i_ld_mask = 4'b1111;
      #1;
      check("fwd_stall", sbif.sb_o_fwd_stall, 1);
      check("fwd_nohit", sbif.sb_o_fwd_hit,   0);
      sbif.sb_i_ld_addr = 32'h80;
      #1;
      check("fwd_miss",  sbif.sb_o_fwd_stall | sbif.sb_o_fwd_hit, 0);
      sbif.sb_i_ld_valid = 1'b0;
      sbif.sb_i_mem_ready = 1'b1;
      repeat (3) cycle();
`endif

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         logic [3:0] m;
         case ($urandom_range(0, 3))
            0:       m = 4'b0000;
            1:       m = op_mask(ST_BYTE);
            2:       m = op_mask(ST_HALF);
            default: m = op_mask(ST_WORD);
         endcase
         drive(1'($urandom_range(0, 1)), $urandom, $urandom, m);
         sbif.sb_i_mem_ready = 1'($urandom_range(0, 2) != 0);
         cycle();
      end
      drive(1'b0, '0, '0, '0);
      sbif.sb_i_mem_ready = 1'b1;
      repeat (DEPTH + 1) cycle();
      check("final_empty", sbif.sb_o_empty, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
